// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU units: datapath width and FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-entry counter still needs a one-bit register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder_if.sv
// Request/result bundle for chunk_adder. Define SUM_FLAGS_EN to add the cout/ovf/zero flags.
interface chunk_adder_if
  import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic             start;
    logic [WIDTH-1:0] inreg1;
    logic [WIDTH-1:0] inreg2;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
`ifdef SUM_FLAGS_EN
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, inreg1, inreg2,
        input  out, busy, done, cout, ovf, zero
    );

    modport slave (
        input  start, inreg1, inreg2,
        output out, busy, done, cout, ovf, zero
    );
`else
    modport master (
        output start, inreg1, inreg2,
        input  out, busy, done
    );

    modport slave (
        input  start, inreg1, inreg2,
        output out, busy, done
    );
`endif

endinterface

// File: rtl/chunk_add_cell.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module chunk_add_cell #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder: out = inreg1 + inreg2, CHUNK bits per clock, start/done handshake.
// Define SUM_FLAGS_EN to also register carry-out, signed overflow and zero flags.
module chunk_adder
  import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    chunk_adder_if.slave   bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic [WIDTH-1:0] sum_next;

    // Start is only honoured when no operation is in flight.
    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (idx_q == LAST_IDX);

    assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

    chunk_add_cell #(
        .CHUNK (CHUNK)
    ) u_cell (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .s    (s_chunk),
        .cout (c_chunk)
    );

    // Result with the current chunk merged in; complete on the last chunk.
    always_comb begin
        sum_next = out_q;
        sum_next[int'(idx_q) * CHUNK +: CHUNK] = s_chunk;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.inreg1;
                b_q     <= bus.inreg2;
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state_q == BUSY) begin
                out_q   <= sum_next;
                carry_q <= c_chunk;
                idx_q   <= last ? '0 : idx_q + 1'b1;
            end
        end
    end

`ifdef SUM_FLAGS_EN
    logic cout_q;
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if ((state_q == BUSY) && last) begin
            cout_q <= c_chunk;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (sum_next == '0);
        end
    end

    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`endif

    assign bus.out  = out_q;
    assign bus.busy = (state_q == BUSY);
    assign bus.done = (state_q == DONE);

endmodule
